// File: rtl/layer4_fc_pkg.sv
// Shared types and constants for the Layer4 FC MAC accumulator.
// Default widths, Q-format shift, saturation limits and rounding constant.
package layer4_fc_pkg;

  localparam int DEF_PROD_WIDTH = 32;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_FRAC_SHIFT = 8;
  localparam int DEF_NUM_OUT    = 10;
  localparam int DEF_IDX_WIDTH  = 4;

  localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [DEF_OUT_WIDTH-1:0] OUT_MIN = 16'sh8000;

  // Half an output LSB, added before the arithmetic shift (round half up).
  localparam int RND_CONST = 1 << (DEF_FRAC_SHIFT - 1);

  typedef enum logic [1:0] {
    S_ACC,
    S_FIN,
    S_OUT
  } state_t;

endpackage

// File: rtl/layer4_fc_quant_sat.sv
// Combinational bias align, round, shift and saturate to Q8.8.
// Optional ReLU on the saturated result when LAYER4_FC_RELU_EN is defined.
module layer4_fc_quant_sat
  import layer4_fc_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [OUT_WIDTH-1:0] bias,
  output logic [OUT_WIDTH-1:0] q
);

`ifdef LAYER4_FC_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  // One extra bit so the rounding add cannot wrap a full-scale sum.
  localparam int RW = ACC_WIDTH + 1;

  logic signed [ACC_WIDTH-1:0] bias_al;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [RW-1:0]        rnd;
  logic signed [RW-1:0]        r;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    bias_al = ACC_WIDTH'($signed(bias)) <<< FRAC_SHIFT;
    sum     = $signed(acc) + bias_al;
    rnd     = RW'(sum) + RW'(RND_CONST);
    r       = rnd >>> FRAC_SHIFT;
    q       = r[OUT_WIDTH-1:0];
    if (r > RW'(OUT_MAX)) begin
      q = OUT_MAX;
    end else if (r < RW'(OUT_MIN)) begin
      q = OUT_MIN;
    end
    if (RELU_EN && q[OUT_WIDTH-1]) begin
      q = '0;
    end
  end

endmodule

// File: rtl/layer4_fc_mac_accum.sv
// Accumulates one neuron's products, adds bias, quantises and emits one activation.
// Build option LAYER4_FC_RELU_EN clamps negative activations to zero.
module layer4_fc_mac_accum
  import layer4_fc_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int NUM_OUT    = DEF_NUM_OUT,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_din,
  input  logic                  prod_vld,
  input  logic                  prod_last,
  output logic                  prod_rdy,
  input  logic [OUT_WIDTH-1:0]  bias_din,
  output logic [OUT_WIDTH-1:0]  act_dout,
  output logic                  act_vld,
  input  logic                  act_rdy,
  output logic [IDX_WIDTH-1:0]  act_idx,
  output logic                  act_last
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_OUT - 1);

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [OUT_WIDTH-1:0]   bias_q;
  logic [OUT_WIDTH-1:0]   q;
  logic                   prod_hs;

  assign prod_rdy = (state_q == S_ACC);
  assign prod_hs  = prod_vld & prod_rdy;

  layer4_fc_quant_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_quant_sat (
    .acc (acc_q),
    .bias(bias_q),
    .q   (q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (prod_hs && prod_last) state_d = S_FIN;
      S_FIN:   state_d = S_OUT;
      S_OUT:   if (act_rdy) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_ACC;
      acc_q    <= '0;
      bias_q   <= '0;
      act_dout <= '0;
      act_vld  <= 1'b0;
      act_idx  <= '0;
      act_last <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_ACC: begin
          if (prod_hs) begin
            acc_q <= acc_q + ACC_WIDTH'($signed(prod_din));
            if (prod_last) bias_q <= bias_din;
          end
        end
        S_FIN: begin
          act_dout <= q;
          act_vld  <= 1'b1;
          act_last <= (act_idx == LAST_IDX);
        end
        S_OUT: begin
          if (act_rdy) begin
            act_vld <= 1'b0;
            acc_q   <= '0;
            act_idx <= (act_idx == LAST_IDX) ? '0 : act_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer4_fc_mac_accum.sv
// Directed self-checking bench for layer4_fc_mac_accum; expected values hand-computed.
// Honours LAYER4_FC_RELU_EN for the negative-result expectations.
module tb_layer4_fc_mac_accum;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [31:0] prod_din;
  logic        prod_vld;
  logic        prod_last;
  logic        prod_rdy;
  logic [15:0] bias_din;
  logic [15:0] act_dout;
  logic        act_vld;
  logic        act_rdy;
  logic [3:0]  act_idx;
  logic        act_last;

  int checks = 0;
  int errors = 0;

`ifdef LAYER4_FC_RELU_EN
  localparam logic [15:0] EXP_NEG_SAT = 16'h0000;
  localparam logic [15:0] EXP_NEG     = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG_SAT = 16'h8000;
  localparam logic [15:0] EXP_NEG     = 16'hFF00;
`endif

  layer4_fc_mac_accum dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .prod_din (prod_din),
    .prod_vld (prod_vld),
    .prod_last(prod_last),
    .prod_rdy (prod_rdy),
    .bias_din (bias_din),
    .act_dout (act_dout),
    .act_vld  (act_vld),
    .act_rdy  (act_rdy),
    .act_idx  (act_idx),
    .act_last (act_last)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one beat at a negedge; it is taken on the following posedge.
  task automatic push(input string tag, input logic [31:0] d, input logic l, input logic [15:0] b);
    check({tag, "_prod_rdy"}, prod_rdy, 1);
    prod_din  = d;
    prod_last = l;
    bias_din  = b;
    prod_vld  = 1'b1;
    @(negedge ap_clk);
    prod_vld  = 1'b0;
    prod_last = 1'b0;
  endtask

  task automatic do_neuron(input string tag, input logic [31:0] d, input int n,
                           input logic [15:0] b, input logic [15:0] exp_dout,
                           input logic [3:0] exp_idx, input logic exp_last, input int hold);
    int cyc;
    logic [15:0] held;
    for (int i = 0; i < n; i++) push(tag, d, (i == n - 1), b);
    // One negedge after the last handshake the block is in FIN; act_vld follows one cycle later.
    check({tag, "_fin_vld"}, act_vld, 0);
    cyc = 0;
    while (!act_vld && cyc < 20) begin
      @(negedge ap_clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 1);
    check({tag, "_dout"}, act_dout, exp_dout);
    check({tag, "_idx"}, act_idx, exp_idx);
    check({tag, "_last"}, act_last, exp_last);
    check({tag, "_out_rdy"}, prod_rdy, 0);
    held = act_dout;
    for (int i = 0; i < hold; i++) begin
      prod_vld  = 1'b1;
      prod_last = 1'b1;
      prod_din  = 32'h1234_5678;
      @(negedge ap_clk);
      check({tag, "_bp_rdy"}, prod_rdy, 0);
      check({tag, "_bp_vld"}, act_vld, 1);
      check({tag, "_bp_dout"}, act_dout, held);
      check({tag, "_bp_idx"}, act_idx, exp_idx);
    end
    prod_vld  = 1'b0;
    prod_last = 1'b0;
    act_rdy   = 1'b1;
    @(negedge ap_clk);
    act_rdy   = 1'b0;
    check({tag, "_done_vld"}, act_vld, 0);
    check({tag, "_done_rdy"}, prod_rdy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst_n  = 1'b0;
    prod_din  = '0;
    prod_vld  = 1'b0;
    prod_last = 1'b0;
    bias_din  = '0;
    act_rdy   = 1'b0;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    check("rst_prod_rdy", prod_rdy, 1);
    check("rst_act_vld", act_vld, 0);
    check("rst_act_dout", act_dout, 0);
    check("rst_act_idx", act_idx, 0);
    check("rst_act_last", act_last, 0);

    // 3 * 1.0 + 0.5 bias = 3.5 -> 0x0380
    do_neuron("sum3", 32'h0001_0000, 3, 16'h0080, 16'h0380, 4'd0, 1'b0, 0);
    do_neuron("rnd_up", 32'h0000_0080, 1, 16'h0000, 16'h0001, 4'd1, 1'b0, 0);
    do_neuron("rnd_dn", 32'h0000_007F, 1, 16'h0000, 16'h0000, 4'd2, 1'b0, 0);
    do_neuron("sat_pos", 32'h7FFF_FFFF, 2, 16'h0000, 16'h7FFF, 4'd3, 1'b0, 0);
    do_neuron("sat_neg", 32'h8000_0000, 2, 16'h0000, EXP_NEG_SAT, 4'd4, 1'b0, 0);
    // Negative result under 5 cycles of backpressure with stray products offered.
    do_neuron("neg_bp", 32'hFFFF_0000, 1, 16'h0000, EXP_NEG, 4'd5, 1'b0, 5);

    for (int k = 6; k < 10; k++)
      do_neuron("idx_sweep", 32'(k) << 16, 1, 16'h0000, 16'(k) << 8, 4'(k), (k == 9), 0);

    do_neuron("idx_wrap", 32'h0001_0000, 1, 16'h0000, 16'h0100, 4'd0, 1'b0, 0);

    push("rst_mid", 32'h0001_0000, 1'b0, 16'h0000);
    push("rst_mid", 32'h0001_0000, 1'b0, 16'h0000);
    ap_rst_n = 1'b0;
    #2;
    check("rst_mid_vld", act_vld, 0);
    check("rst_mid_idx", act_idx, 0);
    check("rst_mid_rdy", prod_rdy, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    do_neuron("rst_fresh", 32'h0002_0000, 1, 16'h0000, 16'h0200, 4'd0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
